// File: rtl/hazard_pkg.sv
// +--------------------------------------------------------------------------+
// | hazard_pkg : shared types and constants for the pipeline hazard control |
// | Rev 1.0    : initial release                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

    localparam int NREG_W_PKG   = 3;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [NREG_W_PKG-1:0] wa;
        logic                  is_load;
    } slot_t;

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// +--------------------------------------------------------------------------+
// | hazard_match : forwarding select / hazard flag for one ID source operand |
// | Config       : HAZARD_WB_FWD_EN enables forwarding from the MEM slot     |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_match
    import hazard_pkg::*;
(
    input  logic [NREG_W_PKG-1:0] src_i,
    input  logic                  use_i,
    input  slot_t                 ex_slot_i,
    input  slot_t                 mem_slot_i,
    output fwd_sel_e              sel_o,
    output logic                  hazard_o
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic unused_mem_load;

    assign w_ex_hit  = ex_slot_i.valid  & ex_slot_i.we  & use_i & (ex_slot_i.wa  == src_i);
    assign w_mem_hit = mem_slot_i.valid & mem_slot_i.we & use_i & (mem_slot_i.wa == src_i);

    // Any MEM-slot producer has its data by WB, load or not
    assign unused_mem_load = mem_slot_i.is_load;

    always_comb begin
        sel_o    = FWD_REG;
        hazard_o = 1'b0;
        if (w_ex_hit) begin
            if (ex_slot_i.is_load) begin
                hazard_o = 1'b1;
            end else begin
                sel_o = FWD_MEM;
            end
        end else if (w_mem_hit) begin
`ifdef HAZARD_WB_FWD_EN
            sel_o = FWD_WB;
`else
            hazard_o = 1'b1;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | hazard_ctrl : forwarding selects, load-use stalls, flush and HLT drain   |
// | Config      : HAZARD_WB_FWD_EN (see hazard_match)                        |
// | Rev 1.0     : initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG_W = NREG_W_PKG
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_ra,
    input  logic [NREG_W-1:0] id_rb,
    input  logic              id_use_ra,
    input  logic              id_use_rb,
    input  logic              id_we,
    input  logic [NREG_W-1:0] id_wa,
    input  logic              id_is_load,
    input  logic              id_is_halt,
    input  logic              flush,
    output logic [1:0]        ra_controll,
    output logic [1:0]        rb_controll,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              halted
);

    localparam logic [1:0] CNT_LOAD = 2'(DRAIN_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    slot_t      ex_slot_q, ex_slot_d;
    slot_t      mem_slot_q;
    fwd_sel_e   ra_sel_q, ra_sel_d;
    fwd_sel_e   rb_sel_q, rb_sel_d;
    logic       halted_q;

    fwd_sel_e   w_ra_sel, w_rb_sel;
    logic       w_ra_hz, w_rb_hz;
    logic       w_stall;
    logic       w_issue;

    hazard_match u_match_ra (
        .src_i      (id_ra),
        .use_i      (id_use_ra),
        .ex_slot_i  (ex_slot_q),
        .mem_slot_i (mem_slot_q),
        .sel_o      (w_ra_sel),
        .hazard_o   (w_ra_hz)
    );

    hazard_match u_match_rb (
        .src_i      (id_rb),
        .use_i      (id_use_rb),
        .ex_slot_i  (ex_slot_q),
        .mem_slot_i (mem_slot_q),
        .sel_o      (w_rb_sel),
        .hazard_o   (w_rb_hz)
    );

    // Flush beats a hazard; HLT is only accepted on a hazard-free cycle
    always_comb begin
        w_stall = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (id_valid && !flush) begin
                    if (w_ra_hz || w_rb_hz) begin
                        w_stall = 1'b1;
                    end else if (id_is_halt) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DRAIN: begin
                w_stall = 1'b1;
                if (cnt_q == 2'd0) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            HALTED: begin
                w_stall = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign w_issue = id_valid && !flush && !w_stall;

    always_comb begin
        ex_slot_d = '0;
        ra_sel_d  = FWD_REG;
        rb_sel_d  = FWD_REG;
        if (w_issue) begin
            ex_slot_d.valid   = 1'b1;
            ex_slot_d.we      = id_we;
            ex_slot_d.wa      = id_wa;
            ex_slot_d.is_load = id_is_load;
            ra_sel_d          = w_ra_sel;
            rb_sel_d          = w_rb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= 2'd0;
            ex_slot_q  <= '0;
            mem_slot_q <= '0;
            ra_sel_q   <= FWD_REG;
            rb_sel_q   <= FWD_REG;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_slot_q  <= ex_slot_d;
            mem_slot_q <= ex_slot_q;
            ra_sel_q   <= ra_sel_d;
            rb_sel_q   <= rb_sel_d;
            halted_q   <= (state_d == HALTED);
        end
    end

    assign ra_controll = ra_sel_q;
    assign rb_controll = rb_sel_q;
    assign stall_if_id = w_stall;
    assign bubble_ex   = w_stall;
    assign halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench for hazard_ctrl            |
// | Rev 1.0        : initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_ra;
    logic [2:0] id_rb;
    logic       id_use_ra;
    logic       id_use_rb;
    logic       id_we;
    logic [2:0] id_wa;
    logic       id_is_load;
    logic       id_is_halt;
    logic       flush;
    logic [1:0] ra_controll;
    logic [1:0] rb_controll;
    logic       stall_if_id;
    logic       bubble_ex;
    logic       halted;

    typedef struct {
        string      tag;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       halt;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_ctrl #(.NREG_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ra       (id_ra),
        .id_rb       (id_rb),
        .id_use_ra   (id_use_ra),
        .id_use_rb   (id_use_rb),
        .id_we       (id_we),
        .id_wa       (id_wa),
        .id_is_load  (id_is_load),
        .id_is_halt  (id_is_halt),
        .flush       (flush),
        .ra_controll (ra_controll),
        .rb_controll (rb_controll),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive, check the combinational stall, queue the registered
    // expectation, clock, then pop and compare.
    task automatic cyc(input string tag,
                       input logic v, input logic [2:0] ra, input logic ura,
                       input logic [2:0] rb, input logic urb,
                       input logic we, input logic [2:0] wa, input logic ld,
                       input logic hlt, input logic fl,
                       input logic xstall, input logic [1:0] xra,
                       input logic [1:0] xrb, input logic xhalt);
        exp_t e;
        id_valid   = v;
        id_ra      = ra;
        id_use_ra  = ura;
        id_rb      = rb;
        id_use_rb  = urb;
        id_we      = we;
        id_wa      = wa;
        id_is_load = ld;
        id_is_halt = hlt;
        flush      = fl;
        #1;
        chk({tag, "_stall"}, {2'b00, stall_if_id, bubble_ex}, {2'b00, xstall, xstall});
        e.tag  = tag;
        e.ra   = xra;
        e.rb   = xrb;
        e.halt = xhalt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 4'h1, 4'h0);
        end else begin
            e = sbq.pop_front();
            chk({e.tag, "_sel"}, {ra_controll, rb_controll}, {e.ra, e.rb});
            chk({e.tag, "_halted"}, {3'b000, halted}, {3'b000, e.halt});
        end
        @(negedge clk);
    endtask

    task automatic nop(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        id_valid   = 1'b0;
        id_use_ra  = 1'b0;
        id_use_rb  = 1'b0;
        id_is_halt = 1'b0;
        flush      = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_sel"}, {ra_controll, rb_controll}, 4'h0);
        chk({tag, "_halted"}, {3'b000, halted}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_stall"}, {2'b00, stall_if_id, bubble_ex}, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_ra = 0; id_rb = 0; id_use_ra = 0; id_use_rb = 0;
        id_we = 0; id_wa = 0; id_is_load = 0; id_is_halt = 0; flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset("reset");

        // ALU -> ALU back-to-back: forward from MEM stage
        cyc("t1_prod", 1, 3'd5, 1, 3'd6, 1, 1, 3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t1_cons", 1, 3'd1, 1, 3'd7, 1, 1, 3'd2, 0, 0, 0, 0, 2'd1, 2'd0, 0);
        nop("t1_n1"); nop("t1_n2");

        // ALU result consumed two instructions later on rb
        cyc("t2_prod", 1, 3'd5, 0, 3'd6, 0, 1, 3'd3, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t2_mid",  1, 3'd5, 1, 3'd6, 1, 1, 3'd4, 0, 0, 0, 0, 2'd0, 2'd0, 0);
`ifdef HAZARD_WB_FWD_EN
        cyc("t2_cons", 1, 3'd6, 1, 3'd3, 1, 1, 3'd5, 0, 0, 0, 0, 2'd0, 2'd2, 0);
`else
        cyc("t2_stall", 1, 3'd6, 1, 3'd3, 1, 1, 3'd5, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        cyc("t2_cons",  1, 3'd6, 1, 3'd3, 1, 1, 3'd5, 0, 0, 0, 0, 2'd0, 2'd0, 0);
`endif
        nop("t2_n1"); nop("t2_n2");

        // Load-use
        cyc("t3_ld",     1, 3'd5, 0, 3'd6, 0, 1, 3'd2, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t3_stall1", 1, 3'd2, 1, 3'd6, 0, 1, 3'd3, 0, 0, 0, 1, 2'd0, 2'd0, 0);
`ifdef HAZARD_WB_FWD_EN
        cyc("t3_cons",   1, 3'd2, 1, 3'd6, 0, 1, 3'd3, 0, 0, 0, 0, 2'd2, 2'd0, 0);
`else
        cyc("t3_stall2", 1, 3'd2, 1, 3'd6, 0, 1, 3'd3, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        cyc("t3_cons",   1, 3'd2, 1, 3'd6, 0, 1, 3'd3, 0, 0, 0, 0, 2'd0, 2'd0, 0);
`endif
        nop("t3_n1"); nop("t3_n2");

        // Flush during a load-use hazard; the killed instruction must not be tracked
        cyc("t4_ld",    1, 3'd5, 0, 3'd6, 0, 1, 3'd2, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t4_flush", 1, 3'd2, 1, 3'd2, 1, 1, 3'd3, 0, 0, 1, 0, 2'd0, 2'd0, 0);
        cyc("t4_after", 1, 3'd3, 1, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        nop("t4_n1"); nop("t4_n2");

        // ra from EX slot, rb from MEM slot
        cyc("t6_p1", 1, 3'd5, 0, 3'd6, 0, 1, 3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t6_p2", 1, 3'd5, 0, 3'd6, 0, 1, 3'd2, 0, 0, 0, 0, 2'd0, 2'd0, 0);
`ifdef HAZARD_WB_FWD_EN
        cyc("t6_cons", 1, 3'd2, 1, 3'd1, 1, 0, 3'd0, 0, 0, 0, 0, 2'd1, 2'd2, 0);
`else
        cyc("t6_s1",   1, 3'd2, 1, 3'd1, 1, 0, 3'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        cyc("t6_s2",   1, 3'd2, 1, 3'd1, 1, 0, 3'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        cyc("t6_cons", 1, 3'd2, 1, 3'd1, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
`endif
        nop("t6_n1"); nop("t6_n2");

        // Matching source that is not actually read
        cyc("t7_prod",  1, 3'd5, 0, 3'd6, 0, 1, 3'd1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t7_nouse", 1, 3'd1, 0, 3'd1, 1, 0, 3'd0, 0, 0, 0, 0, 2'd0, 2'd1, 0);
        nop("t7_n1"); nop("t7_n2");

        // HLT drains for three cycles, then halts until reset
        cyc("t5_hlt", 1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        cyc("t5_d1",  0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        cyc("t5_d2",  0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 1, 2'd0, 2'd0, 0);
        cyc("t5_d3",  0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 2'd0, 2'd0, 1);
        cyc("t5_hf",  1, 3'd1, 1, 3'd2, 1, 1, 3'd3, 0, 0, 1, 1, 2'd0, 2'd0, 1);
        do_reset("t5_rst");
        nop("t5_run");

        // Reset in the middle of DRAIN
        cyc("t8_hlt", 1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1, 0, 0, 2'd0, 2'd0, 0);
        cyc("t8_d1",  0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
        do_reset("t8_rst");
        for (int i = 0; i < 4; i++) nop("t8_run");
        cyc("t8_prod", 1, 3'd5, 0, 3'd6, 0, 1, 3'd4, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        cyc("t8_cons", 1, 3'd4, 1, 3'd4, 1, 1, 3'd5, 0, 0, 0, 0, 2'd1, 2'd1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage core. Tracks the destination register of every instruction in flight past decode and generates the EX-stage forwarding selects (`ra_controll`, `rb_controll`) consumed by the execute datapath. Issues load-use stalls and bubbles, honours branch flushes, and drains and halts the pipeline on HLT. Sits beside the ID/EX pipeline register, fed by the decoder and the EX-stage branch unit.

## Interface
Parameters:
- `NREG_W`, 3: register index width (8 general registers)

Ports:
- `clk` in 1: core clock
- `rst_n` in 1: synchronous reset, active-low
- `id_valid` in 1: valid instruction in ID
- `id_ra`, `id_rb` in NREG_W: source register indices of ID instruction
- `id_use_ra`, `id_use_rb` in 1: corresponding source is actually read
- `id_we` in 1: ID instruction writes a register
- `id_wa` in NREG_W: destination register index
- `id_is_load` in 1: ID instruction is LD (data available only at WB)
- `id_is_halt` in 1: ID instruction is HLT
- `flush` in 1: taken branch resolved in EX; kill the ID instruction
- `ra_controll`, `rb_controll` out 2: forwarding select for the instruction now in EX. 0 = register file, 1 = MEM-stage result, 2 = WB-stage data, 3 = never driven
- `stall_if_id` out 1: hold PC and the IF/ID register
- `bubble_ex` out 1: load a NOP into ID/EX
- `halted` out 1: pipeline fully drained after HLT

## Operation
- Shadow slots `ex_slot` and `mem_slot`, each holding {valid, we, wa, is_load}. Advance every cycle: `mem_slot <= ex_slot`; `ex_slot <=` ID info, or invalid when `bubble_ex`, `flush`, or `!id_valid`.
- A source matches a slot when valid & we & use & (wa == src).
- Forward decision for each source, evaluated in ID, priority order:
  - `ex_slot` match, not a load: select 1
  - `ex_slot` match, load: hazard
  - `mem_slot` match: select 2
  - otherwise: select 0
- The register file is write-through, so no WB-slot tracking is needed.
- On hazard (RUN, `id_valid`, no `flush`):
  - `stall_if_id` = 1 and `bubble_ex` = 1 for that cycle.
  - Next cycle the load sits in `mem_slot` and resolves to select 2.
- `flush` overrides everything: stall and bubble are 0, `ex_slot` is invalidated, and the registered selects load 0.
- FSM states:
  - RUN:
    - HLT in ID with `id_valid`, no flush, no hazard: go to DRAIN with counter = 2. The HLT enters `ex_slot`.
    - Otherwise remain in RUN.
  - DRAIN: `stall_if_id` = 1 and `bubble_ex` = 1 every cycle. `flush` is ignored. The counter decrements each cycle; at 0, go to HALTED.
  - HALTED: `halted` = 1, stall and bubble held at 1. Exit only via reset.

## Timing
- Reset values: both selects 0, both slots invalid, state RUN, counter 0, `halted` 0.
- `ra_controll` and `rb_controll` are registered. They are computed in ID and valid during the EX cycle of that instruction (1-cycle latency). When `bubble_ex` is asserted they load 0.
- `stall_if_id` and `bubble_ex` are combinational from the ID inputs, the slots and the FSM state, in the same cycle. In RUN with `id_valid` = 0 both are 0.
- `halted` is registered. It rises 3 cycles after the cycle the HLT left ID (HLT has then completed WB).
- Simultaneous hazard and flush: flush wins, no stall.
- Simultaneous HLT and hazard: stall first; HLT is accepted in a later cycle.
- Reset during DRAIN or HALTED returns to RUN with all slots invalid on the next edge.

## Configuration
- `HAZARD_WB_FWD_EN` defined: MEM-slot matches forward with select 2. A load-use hazard costs 1 stall cycle.
- `HAZARD_WB_FWD_EN` undefined: select 2 is never produced, and a MEM-slot match is treated as a hazard (stall + bubble).
  - Load-use costs 2 stall cycles.
  - An ALU result consumed two instructions later costs 1 stall cycle.

## Structure
- Package `hazard_pkg`:
  - enum `fwd_sel_e` (`FWD_REG` = 0, `FWD_MEM` = 1, `FWD_WB` = 2)
  - struct `slot_t` {valid, we, wa, is_load}
  - enum `hz_state_e` (RUN, DRAIN, HALTED)
  - constant `DRAIN_CYCLES` = 3
- One sub-module, `hazard_match`: given one source (index, use) and both slots, returns `fwd_sel_e` plus a hazard flag. Instantiated twice (ra, rb).

## Test plan
- ADD r1 then ADD reading r1 as ra → `ra_controll` = 1 during the consumer's EX; no stall.
- ADD r3, one unrelated instruction, then consumer reading r3 as rb → `rb_controll` = 2. With the macro undefined: 1 stall cycle, then `rb_controll` = 0.
- LD r2 then ADD reading r2 → `stall_if_id` = 1 and `bubble_ex` = 1 for exactly 1 cycle, then `ra_controll` = 2. With the macro undefined: 2 stall cycles, then 0.
- `flush` = 1 while a load-use hazard is present in ID → `stall_if_id` = 0, `bubble_ex` = 0, next cycle both selects 0.
- HLT accepted → stall held high, `halted` = 1 exactly 3 cycles later. A separate run asserts `rst_n` = 0 during DRAIN → RUN, `halted` 0, selects 0.
- ra matches `ex_slot` and rb matches `mem_slot` → `ra_controll` = 1, `rb_controll` = 2. A matching source with `id_use_ra` = 0 → select 0.
